// File: rtl/smoldvi_pkg.sv
// Shared TMDS definitions for the smoldvi receive path: control symbols and
// word-alignment state encoding, also used by the TMDS decoder.
package smoldvi_pkg;

   // Control symbols, LSB is the first bit on the wire.
   localparam logic [9:0] TMDS_CTRL_00 = 10'b1101010100;
   localparam logic [9:0] TMDS_CTRL_01 = 10'b0010101011;
   localparam logic [9:0] TMDS_CTRL_10 = 10'b0101010100;
   localparam logic [9:0] TMDS_CTRL_11 = 10'b1010101011;

   typedef enum logic {
      SEARCH = 1'b0,
      LOCKED = 1'b1
   } align_state_e;

   function automatic logic is_tmds_ctrl(input logic [9:0] w);
      return (w == TMDS_CTRL_00) || (w == TMDS_CTRL_01) ||
             (w == TMDS_CTRL_10) || (w == TMDS_CTRL_11);
   endfunction

endpackage

// File: rtl/smoldvi_bit_window.sv
// Combinational 20->10 selector: picks the 10-bit word ending offset_i bits
// before the newest received bit (offset 0 = ends with the newest bit).
module smoldvi_bit_window (
   input  logic [19:0] hist_i,
   input  logic [3:0]  offset_i,
   output logic [9:0]  word_o
);

   logic [19:0] shifted;

   always_comb begin
      shifted = hist_i >> (5'd10 - {1'b0, offset_i});
      word_o  = shifted[9:0];
   end

endmodule

// File: rtl/smoldvi_rx_word_align.sv
// TMDS lane word aligner: rebuilds 10-bit words from DDR bit pairs and
// bit-slips until runs of control symbols line up, then holds lock.
import smoldvi_pkg::*;

module smoldvi_rx_word_align #(
   parameter int CTRL_RUN     = 8,
   parameter int SEARCH_WORDS = 64,
   parameter int LOSS_WORDS   = 4096
) (
   input  logic       clk_x5,
   input  logic       rst_x5,
   input  logic       d0,
   input  logic       d1,
   output logic [9:0] word_out,
   output logic       word_valid,
   output logic       is_ctrl,
   output logic       locked,
   output logic [3:0] slip_offset
);

   localparam int RUN_W    = $clog2(CTRL_RUN + 1);
   localparam int WCNT_MAX = (SEARCH_WORDS > LOSS_WORDS) ? SEARCH_WORDS : LOSS_WORDS;
   localparam int WCNT_W   = $clog2(WCNT_MAX + 1);

   localparam logic [RUN_W-1:0]  RUN_LIM    = RUN_W'(CTRL_RUN);
   localparam logic [WCNT_W-1:0] SEARCH_LIM = WCNT_W'(SEARCH_WORDS);
   localparam logic [WCNT_W-1:0] LOSS_LIM   = WCNT_W'(LOSS_WORDS);

   // The two oldest history bits age out before any window offset can reach
   // them, so only the upper 18 bits of the 20-bit history are stored.
   logic [17:0]       hist_q;
   logic [19:0]       hist_d;
   logic [2:0]        phase_q, phase_d;
   logic [3:0]        slip_q, slip_d;
   logic [RUN_W-1:0]  run_q, run_d, run_inc;
   logic [WCNT_W-1:0] wcnt_q, wcnt_d, wcnt_inc;
   align_state_e      state_q, state_d;
   logic [9:0]        word_q, word_d;
   logic              vld_q, vld_d;
   logic              ctrl_q, ctrl_d;
   logic [9:0]        win;
   logic              win_ctrl;
   logic              capture;

   assign hist_d = {d1, d0, hist_q};

   smoldvi_bit_window u_window (
      .hist_i   (hist_d),
      .offset_i (slip_q),
      .word_o   (win)
   );

   assign win_ctrl = is_tmds_ctrl(win);
   assign capture  = (phase_q == 3'd4);
   assign run_inc  = (run_q == '1) ? run_q : run_q + RUN_W'(1);
   assign wcnt_inc = (wcnt_q == '1) ? wcnt_q : wcnt_q + WCNT_W'(1);

   always_comb begin
      phase_d = capture ? 3'd0 : phase_q + 3'd1;
      state_d = state_q;
      slip_d  = slip_q;
      run_d   = run_q;
      wcnt_d  = wcnt_q;
      word_d  = word_q;
      ctrl_d  = ctrl_q;
      vld_d   = capture;
      if (capture) begin
         word_d = win;
         ctrl_d = win_ctrl;
         case (state_q)
            SEARCH: begin
               run_d  = win_ctrl ? run_inc : '0;
               wcnt_d = wcnt_inc;
               // Lock takes priority over a slip landing on the same word.
               if (win_ctrl && (run_inc == RUN_LIM)) begin
                  state_d = LOCKED;
                  run_d   = '0;
                  wcnt_d  = '0;
               end else if (wcnt_inc == SEARCH_LIM) begin
                  slip_d = (slip_q == 4'd9) ? 4'd0 : slip_q + 4'd1;
                  run_d  = '0;
                  wcnt_d = '0;
               end
            end
            LOCKED: begin
               if (win_ctrl) begin
                  wcnt_d = '0;
               end else begin
                  wcnt_d = wcnt_inc;
                  if (wcnt_inc == LOSS_LIM) begin
                     state_d = SEARCH;
                     run_d   = '0;
                     wcnt_d  = '0;
                  end
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk_x5 or posedge rst_x5) begin
      if (rst_x5) begin
         hist_q  <= '0;
         phase_q <= '0;
         slip_q  <= '0;
         run_q   <= '0;
         wcnt_q  <= '0;
         state_q <= SEARCH;
         word_q  <= '0;
         vld_q   <= 1'b0;
         ctrl_q  <= 1'b0;
      end else begin
         hist_q  <= hist_d[19:2];
         phase_q <= phase_d;
         slip_q  <= slip_d;
         run_q   <= run_d;
         wcnt_q  <= wcnt_d;
         state_q <= state_d;
         word_q  <= word_d;
         vld_q   <= vld_d;
         ctrl_q  <= ctrl_d;
      end
   end

   assign word_out    = word_q;
   assign word_valid  = vld_q;
   assign is_ctrl     = ctrl_q;
   assign locked      = (state_q == LOCKED);
   assign slip_offset = slip_q;

endmodule
